serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the team's existing single-bit `fulladd` cell.
- It is the sequential stage that feeds `fulladd`: it loads parallel operands, presents one bit pair per clock to `fulladd`, and registers its carry back.
- Result is parallel sum plus carry-out, with a start/done handshake.
- Serves as the area-minimal adder for slow datapaths and as the consumer-side exerciser of `fulladd`.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- c_in  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while the bit-serial addition runs (state RUN).
- done  output  1  one-cycle pulse: sum/c_out just updated.
- sum  output  WIDTH  registered result; holds until the next completion.
- c_out  output  1  registered carry-out; holds until the next completion.

Behaviour:
- Reset (async, any time including mid-RUN):
  - state = IDLE.
  - busy, done, sum, c_out, internal shift registers, carry flop and counter all = 0.
  - An in-flight operation is discarded; no done is issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - At an edge with start=1: load shift_a<=a, shift_b<=b, carry<=c_in, cnt<=0; go to RUN.
  - With start=0: stay in IDLE.
- RUN, each edge:
  - `fulladd` inputs are (shift_a[0], shift_b[0], carry).
  - Its sum bit shifts into acc at the MSB (acc shifts right).
  - shift_a and shift_b shift right with zero fill.
  - carry <= fulladd c_out; cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1: sum <= final acc (including this bit), c_out <= final carry, done <= 1, go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1 during it.
  - Next edge: done <= 0, go to IDLE.
  - start is ignored in DONE.
- Latency: start sampled at edge E0.
  - busy is high after E0 through edge E0+WIDTH.
  - done is high for the single cycle between edges E0+WIDTH and E0+WIDTH+1.
- Back-to-back throughput: one result per WIDTH+2 cycles (start held high continuously).
- start while busy or in DONE has no effect, is not queued, and does not corrupt operands.
- a, b and c_in may change freely after the accepting edge.
- sum and c_out change only on the completion edge or on reset; they never show partial results.
- Arithmetic: {c_out,sum} = a + b + c_in, unsigned, exact for all WIDTH-bit inputs. Wrap-around is carried in c_out only.
- WIDTH=1: a single RUN cycle; done follows one edge after the accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Extra output port `overflow` (1 bit), registered with sum.
  - overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), i.e. two's-complement signed overflow. In the serial datapath it is computed as carry-into-MSB XOR carry-out-of-MSB.
  - Reset value 0; held until the next completion.
- Undefined: no port, no logic; behaviour otherwise identical.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH constant.
- Sub-module: the existing `fulladd(sum, c_out, a, b, c_in)`, instantiated once.
- The datapath registers and FSM stay in serial_adder; no further split.

Test Plan:
- WIDTH=8: a=8'h00, b=8'h00, c_in=0, start → done pulse exactly 8 edges after the accepting edge; sum=8'h00, c_out=0; busy high for exactly 8 cycles.
- WIDTH=8 wrap: a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, c_out=1. Then a=8'hA5, b=8'h5A, c_in=1 → sum=8'h00, c_out=1.
- Start ignored: a=8'h12, b=8'h34 accepted; at RUN cycle 3 pulse start with a=8'hFF, b=8'hFF → single done, sum=8'h46, c_out=0; no second operation follows.
- Reset mid-operation: accept a=8'h0F, b=8'h01, assert reset at RUN cycle 4 for 1 cycle → all outputs 0, no done. A fresh start then gives a=8'h03 + b=8'h04 = sum 8'h07.
- WIDTH=1: all 8 (a,b,c_in) combinations → {c_out,sum} equals the full-adder truth table (000→00 … 111→11); done one edge after each accepting edge.
- With SERIAL_ADDER_OVERFLOW_EN, WIDTH=8:
  - 8'h7F+8'h01 → sum=8'h80, c_out=0, overflow=1.
  - 8'hFF+8'h01 → overflow=0, c_out=1.
  - 8'h80+8'h80 → sum=8'h00, c_out=1, overflow=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladd.sv
// Single-bit full-adder cell; the serial adder drives one instance of it per clock.
module fulladd (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: loads operands on start, adds LSB-first through one fulladd.
// Optional SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;

    fulladd u_fa (
        .sum   (fa_sum),
        .c_out (fa_cout),
        .a     (shift_a[0]),
        .b     (shift_b[0]),
        .c_in  (carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts acc holds the full result.
    always_comb begin
        acc_next = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            shift_a  <= '0;
            shift_b  <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        carry   <= c_in;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    acc     <= acc_next;
                    carry   <= fa_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (last) begin
                        sum   <= acc_next;
                        c_out <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // carry here is the carry into the MSB position
                        overflow <= carry ^ fa_cout;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
